// File: rtl/pe_pkg.sv
// Shared types and default geometry for the PE multiply-accumulate stage.
package pe_pkg;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_BUSY = 1'b1
    } drain_state_e;

    localparam int A_PART_WIDTH_DEF = 1;
    localparam int B_NUM_WIDTH_DEF  = 1;
    localparam int K_NUM_WIDTH_DEF  = 1;
    localparam int A_PART    = 1 << A_PART_WIDTH_DEF;
    localparam int B_NUM     = 1 << B_NUM_WIDTH_DEF;
    localparam int K_NUM     = 1 << K_NUM_WIDTH_DEF;
    localparam int TILE_SIZE = A_PART * B_NUM;

endpackage

// File: rtl/acc_bank.sv
// Ping-pong accumulator storage: one read-modify-write port and one drain read port.
// Both reads are combinational; writes land on the clock edge. No reset on contents.
module acc_bank #(
    parameter int ADDR_WIDTH = 2,
    parameter int ACC_WIDTH  = 17
) (
    input  logic                  clk,
    input  logic                  rmw_bank_i,
    input  logic [ADDR_WIDTH-1:0] rmw_addr_i,
    input  logic                  rmw_we_i,
    input  logic [ACC_WIDTH-1:0]  rmw_wdat_i,
    output logic [ACC_WIDTH-1:0]  rmw_rdat_o,
    input  logic                  drn_bank_i,
    input  logic [ADDR_WIDTH-1:0] drn_addr_i,
    output logic [ACC_WIDTH-1:0]  drn_rdat_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [ACC_WIDTH-1:0] mem_q [2][DEPTH];

    always_ff @(posedge clk) begin
        if (rmw_we_i) begin
            mem_q[rmw_bank_i][rmw_addr_i] <= rmw_wdat_i;
        end
    end

    assign rmw_rdat_o = mem_q[rmw_bank_i][rmw_addr_i];
    assign drn_rdat_o = mem_q[drn_bank_i][drn_addr_i];

endmodule

// File: rtl/pe_mac_accum.sv
// Multiplies loader A/B pairs and accumulates a C tile; finished tile drains via valid/ready.
// Pair at edge N is written at N+1; no backpressure to the loader, overlapping tiles flag an error.
module pe_mac_accum
    import pe_pkg::*;
#(
    parameter int D_WIDTH      = 64,
    parameter int A_PART_WIDTH = A_PART_WIDTH_DEF,
    parameter int B_NUM_WIDTH  = B_NUM_WIDTH_DEF,
    parameter int K_NUM_WIDTH  = K_NUM_WIDTH_DEF,
    parameter int ACC_WIDTH    = 2*D_WIDTH + K_NUM_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [D_WIDTH-1:0]                data_A_in,
    input  logic [D_WIDTH-1:0]                data_B_in,
    input  logic                              valid_AB_in,
    output logic [ACC_WIDTH-1:0]              data_C_out,
    output logic [B_NUM_WIDTH+A_PART_WIDTH-1:0] index_C_out,
    output logic                              valid_C_out,
    input  logic                              ready_C_in,
    output logic                              tile_done_out,
    output logic                              overflow_err_out
);

    localparam int ADDR_W = A_PART_WIDTH + B_NUM_WIDTH;
    localparam int CNT_W  = ADDR_W + K_NUM_WIDTH;
    localparam int P_W    = 2 * D_WIDTH;

    logic signed [P_W-1:0]       a_ext, b_ext, prod_d, prod_q;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic                        prod_vld_q;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        k_first, tile_done, tile_done_q;
    logic [ACC_WIDTH-1:0]        rmw_rdat, rmw_wdat, drn_rdat;
    logic                        acc_sel_q, acc_sel_d;
    drain_state_e                drn_state_q, drn_state_d;
    logic [ADDR_W-1:0]           idx_q, idx_d, drn_addr;
    logic [ACC_WIDTH-1:0]        dat_q, dat_d;
    logic                        drn_bank, drn_fire, drn_last, drn_free, drn_start;
    logic                        ovf_q, ovf_d;

    assign a_ext  = {{D_WIDTH{data_A_in[D_WIDTH-1]}}, data_A_in};
    assign b_ext  = {{D_WIDTH{data_B_in[D_WIDTH-1]}}, data_B_in};
    assign prod_d = a_ext * b_ext;

    // Counter is {k, j, i}; its low bits are directly the {j, i} bank address.
    assign k_first   = (cnt_q[CNT_W-1:ADDR_W] == '0);
    assign tile_done = prod_vld_q & (&cnt_q);
    assign cnt_d     = prod_vld_q ? cnt_q + CNT_W'(1) : cnt_q;
    assign prod_ext  = ACC_WIDTH'(prod_q);
    assign rmw_wdat  = k_first ? prod_ext : rmw_rdat + prod_ext;

    assign drn_fire  = (drn_state_q == DRAIN_BUSY) & ready_C_in;
    assign drn_last  = drn_fire & (&idx_q);
    assign drn_free  = (drn_state_q == DRAIN_IDLE) | drn_last;
    assign drn_start = tile_done & drn_free;
    // At start the just-completed bank is still the write bank; afterwards it is the other one.
    assign drn_bank  = drn_start ? acc_sel_q : ~acc_sel_q;
    assign drn_addr  = drn_start ? '0 : idx_q + ADDR_W'(1);

    acc_bank #(
        .ADDR_WIDTH (ADDR_W),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_acc_bank (
        .clk        (clk),
        .rmw_bank_i (acc_sel_q),
        .rmw_addr_i (cnt_q[ADDR_W-1:0]),
        .rmw_we_i   (prod_vld_q),
        .rmw_wdat_i (rmw_wdat),
        .rmw_rdat_o (rmw_rdat),
        .drn_bank_i (drn_bank),
        .drn_addr_i (drn_addr),
        .drn_rdat_o (drn_rdat)
    );

    always_comb begin
        drn_state_d = drn_state_q;
        idx_d       = idx_q;
        dat_d       = dat_q;
        acc_sel_d   = acc_sel_q;
        ovf_d       = ovf_q | (tile_done & ~drn_free);
        if (drn_start) begin
            drn_state_d = DRAIN_BUSY;
            idx_d       = '0;
            dat_d       = drn_rdat;
            acc_sel_d   = ~acc_sel_q;
        end else if (drn_last) begin
            drn_state_d = DRAIN_IDLE;
        end else if (drn_fire) begin
            idx_d = idx_q + ADDR_W'(1);
            dat_d = drn_rdat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            cnt_q       <= '0;
            tile_done_q <= 1'b0;
            acc_sel_q   <= 1'b0;
            drn_state_q <= DRAIN_IDLE;
            idx_q       <= '0;
            dat_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            prod_vld_q  <= valid_AB_in;
            cnt_q       <= cnt_d;
            tile_done_q <= tile_done;
            acc_sel_q   <= acc_sel_d;
            drn_state_q <= drn_state_d;
            idx_q       <= idx_d;
            dat_q       <= dat_d;
            ovf_q       <= ovf_d;
        end
    end

    assign data_C_out       = dat_q;
    assign index_C_out      = idx_q;
    assign valid_C_out      = (drn_state_q == DRAIN_BUSY);
    assign tile_done_out    = tile_done_q;
    assign overflow_err_out = ovf_q;

endmodule

// File: tb/tb_pe_mac_accum.sv
// Directed bench for pe_mac_accum with D_WIDTH=8 and a 2x2x2 tile; a 16-bit accumulator copy checks wrap.
module tb_pe_mac_accum;

    logic        clk;
    logic        rst;
    logic [7:0]  data_A_in, data_B_in;
    logic        valid_AB_in;
    logic        ready_C_in;
    logic [16:0] data_C_out;
    logic [1:0]  index_C_out;
    logic        valid_C_out, tile_done_out, overflow_err_out;
    logic [15:0] c16_dat;
    logic [1:0]  c16_idx;
    logic        c16_vld, c16_done, c16_ovf;

    int vectors    = 0;
    int miscompares = 0;
    int sa[8];
    int sb[8];
    logic [16:0] exp_c[4];

    pe_mac_accum #(.D_WIDTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_A_in        (data_A_in),
        .data_B_in        (data_B_in),
        .valid_AB_in      (valid_AB_in),
        .data_C_out       (data_C_out),
        .index_C_out      (index_C_out),
        .valid_C_out      (valid_C_out),
        .ready_C_in       (ready_C_in),
        .tile_done_out    (tile_done_out),
        .overflow_err_out (overflow_err_out)
    );

    pe_mac_accum #(.D_WIDTH(8), .ACC_WIDTH(16)) dut16 (
        .clk              (clk),
        .rst              (rst),
        .data_A_in        (data_A_in),
        .data_B_in        (data_B_in),
        .valid_AB_in      (valid_AB_in),
        .data_C_out       (c16_dat),
        .index_C_out      (c16_idx),
        .valid_C_out      (c16_vld),
        .ready_C_in       (ready_C_in),
        .tile_done_out    (c16_done),
        .overflow_err_out (c16_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives n pairs from sa/sb starting at a negedge; ready is raised before pair rdy_at.
    task automatic send_tile(input bit gaps, input int rdy_at, input int n);
        for (int p = 0; p < n; p++) begin
            if (gaps) begin
                valid_AB_in = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            if (p == rdy_at) ready_C_in = 1'b1;
            data_A_in   = 8'(sa[p]);
            data_B_in   = 8'(sb[p]);
            valid_AB_in = 1'b1;
            @(negedge clk);
        end
        valid_AB_in = 1'b0;
    endtask

    // Called at the negedge where entry 0 is presented, with ready high.
    task automatic drain_all(input string name);
        for (int e = 0; e < 4; e++) begin
            chk($sformatf("%s_vld%0d", name, e), 32'(valid_C_out), 32'd1);
            chk($sformatf("%s_idx%0d", name, e), 32'(index_C_out), 32'(e));
            chk($sformatf("%s_dat%0d", name, e), 32'(data_C_out), 32'(exp_c[e]));
            if (e > 0) chk($sformatf("%s_done_low%0d", name, e), 32'(tile_done_out), 32'd0);
            @(negedge clk);
        end
        chk({name, "_vld_end"}, 32'(valid_C_out), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_dat"},  32'(data_C_out),       32'd0);
        chk({name, "_idx"},  32'(index_C_out),      32'd0);
        chk({name, "_vld"},  32'(valid_C_out),      32'd0);
        chk({name, "_done"}, 32'(tile_done_out),    32'd0);
        chk({name, "_ovf"},  32'(overflow_err_out), 32'd0);
    endtask

    task automatic load_set1();
        sa    = '{1, 2, 1, 2, 5, 6, 5, 6};
        sb    = '{3, 3, 4, 4, 7, 7, 8, 8};
        exp_c = '{17'd38, 17'd48, 17'd44, 17'd56};
    endtask

    initial begin
        rst         = 1'b1;
        data_A_in   = '0;
        data_B_in   = '0;
        valid_AB_in = 1'b0;
        ready_C_in  = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single contiguous tile
        load_set1();
        send_tile(1'b0, -1, 8);
        chk("single_done_before", 32'(tile_done_out), 32'd0);
        @(negedge clk);
        chk("single_done", 32'(tile_done_out), 32'd1);
        drain_all("single");

        // Same tile with random gaps in valid
        send_tile(1'b1, -1, 8);
        @(negedge clk);
        chk("gap_done", 32'(tile_done_out), 32'd1);
        drain_all("gap");

        // Hold ready low for 5 cycles: entry 0 must stay put
        ready_C_in = 1'b0;
        send_tile(1'b0, -1, 8);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_idx%0d", c), 32'(index_C_out), 32'd0);
            chk($sformatf("bp_hold_dat%0d", c), 32'(data_C_out), 32'd38);
            chk($sformatf("bp_hold_vld%0d", c), 32'(valid_C_out), 32'd1);
        end
        ready_C_in = 1'b1;
        drain_all("bp");

        // Signed extreme: (-128)*(-128) summed twice; 16-bit copy wraps to 0x8000
        for (int p = 0; p < 8; p++) begin
            sa[p] = -128;
            sb[p] = -128;
        end
        send_tile(1'b0, -1, 8);
        @(negedge clk);
        for (int e = 0; e < 4; e++) begin
            chk($sformatf("wrap17_dat%0d", e), 32'(data_C_out), 32'h0000_8000);
            chk($sformatf("wrap16_dat%0d", e), 32'(c16_dat),    32'h0000_8000);
            chk($sformatf("wrap16_idx%0d", e), 32'(c16_idx),    32'(e));
            @(negedge clk);
        end

        // Second tile completes while the first is stalled in drain
        ready_C_in = 1'b0;
        load_set1();
        send_tile(1'b0, -1, 8);
        for (int p = 0; p < 8; p++) begin
            sa[p] = 1;
            sb[p] = 1;
        end
        send_tile(1'b0, -1, 8);
        @(negedge clk);
        chk("ovl_done",  32'(tile_done_out),    32'd1);
        chk("ovl_err",   32'(overflow_err_out), 32'd1);
        chk("ovl_hold",  32'(data_C_out),       32'd38);
        ready_C_in = 1'b1;
        drain_all("ovl");
        chk("ovl_sticky", 32'(overflow_err_out), 32'd1);

        // Reset after 5 pairs of a tile clears everything
        load_set1();
        send_tile(1'b0, -1, 5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        send_tile(1'b0, -1, 8);
        @(negedge clk);
        chk("midrst_done", 32'(tile_done_out), 32'd1);
        drain_all("fresh");

        // Final acceptance of tile 1 lands on tile 2 completion
        ready_C_in = 1'b0;
        send_tile(1'b0, -1, 8);
        sa    = '{3, -1, 3, -1, 2, 4, 2, 4};
        sb    = '{2, 2, -5, -5, 1, 1, 3, 3};
        send_tile(1'b0, 5, 8);
        chk("coin_last_idx", 32'(index_C_out), 32'd3);
        chk("coin_last_dat", 32'(data_C_out),  32'd56);
        exp_c = '{17'd8, 17'd2, -17'sd9, 17'd17};
        @(negedge clk);
        chk("coin_done", 32'(tile_done_out),    32'd1);
        chk("coin_err",  32'(overflow_err_out), 32'd0);
        drain_all("coin");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_mac_accum.md
# pe_mac_accum

Processing-element compute stage directly downstream of the per-PE A/B loader. Consumes the loader's A/B operand stream (`data_A`, `data_B`, `valid_AB`), multiplies each pair, and accumulates into a local C tile of A_PART × B_NUM partial sums across K_NUM outer-product steps. Uses ping-pong accumulator banks so a finished tile drains through a valid/ready port while the next tile accumulates. There is no backpressure toward the loader.

## Interface
Parameters:
- `D_WIDTH`, 64, operand width; signed two's complement integer.
- `A_PART_WIDTH`, 1, log2 of A rows held per PE; A_PART = 1<<A_PART_WIDTH.
- `B_NUM_WIDTH`, 1, log2 of B columns per k-step; B_NUM = 1<<B_NUM_WIDTH.
- `K_NUM_WIDTH`, 1, log2 of k-steps per tile; K_NUM = 1<<K_NUM_WIDTH.
- `ACC_WIDTH`, 2*D_WIDTH+K_NUM_WIDTH, accumulator width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `data_A_in`  in  D_WIDTH  A operand from loader.
- `data_B_in`  in  D_WIDTH  B operand from loader.
- `valid_AB_in`  in  1  pair valid; one pair per cycle max.
- `data_C_out`  out  ACC_WIDTH  drained partial sum.
- `index_C_out`  out  B_NUM_WIDTH+A_PART_WIDTH  {j, i} of `data_C_out`.
- `valid_C_out`  out  1  drain data valid.
- `ready_C_in`  in  1  downstream accept.
- `tile_done_out`  out  1  one-cycle pulse on tile completion.
- `overflow_err_out`  out  1  sticky: a tile completed while the previous tile was still draining.

## Operation
- Pair order is fixed: i (0..A_PART-1) is minor, j (0..B_NUM-1) is next, k (0..K_NUM-1) is major. Write-side counters i_cnt, j_cnt, k_cnt advance once per accepted pair.
- Stage 1: register `product = data_A_in * data_B_in` (2*D_WIDTH, signed), plus the valid bit.
- Stage 2: accumulator address {j_cnt, i_cnt} in bank `acc_sel`.
  - k_cnt == 0: write the sign-extended product. This overwrites the location, so no clear pass is needed.
  - Otherwise: write acc + product, wrapping modulo 2^ACC_WIDTH.
- Tile completes on the write with i, j, k all at maximum.
  - Counters wrap to 0 and `tile_done_out` pulses.
  - If the drain side is idle: toggle `acc_sel` and start draining the completed bank.
  - If the drain side is busy: set `overflow_err_out`. Do not toggle `acc_sel`; the completed tile is discarded and is overwritten by the next tile's k=0 writes. The drain in progress continues unaffected.
- Drain FSM:
  - DRAIN_IDLE → DRAIN_BUSY on tile completion with the drain side idle.
  - In DRAIN_BUSY, present entries in index order 0..A_PART*B_NUM-1, i minor. Advance on `valid_C_out && ready_C_in`.
  - DRAIN_BUSY → DRAIN_IDLE on acceptance of the last entry.
- Address hazards are impossible: consecutive writes target distinct addresses because A_PART ≥ 2.

## Timing
- Reset values: `data_C_out`=0, `index_C_out`=0, `valid_C_out`=0, `tile_done_out`=0, `overflow_err_out`=0. Also reset: all counters, `acc_sel`=0, FSM=DRAIN_IDLE. Accumulator contents are not reset.
- Latency:
  - Pair accepted at edge N: stage 1 registered at N; accumulator written at N+1.
  - `tile_done_out` is high in the cycle after the final write.
  - `valid_C_out` rises in that same cycle, presenting index 0.
- Drain throughput is 1 entry/cycle while `ready_C_in` stays high.
- While `valid_C_out` is high and `ready_C_in` is low, `data_C_out` and `index_C_out` must hold stable.
- The drain read port is combinational from its bank, and outputs are registered. On acceptance, the next entry appears in the following cycle with no bubble.
- Simultaneous events:
  - Final drain acceptance in the same cycle as tile completion counts as drain idle: swap occurs and no error is flagged.
  - `valid_AB_in` during draining is always accepted.
- Reset mid-tile or mid-drain discards all partial state. The first pair after reset is treated as i=j=k=0.

## Structure
- Package `pe_pkg`: drain-state enum {DRAIN_IDLE, DRAIN_BUSY}; localparams A_PART, B_NUM, K_NUM, TILE_SIZE = A_PART*B_NUM.
- One sub-module, `acc_bank`: two banks of TILE_SIZE × ACC_WIDTH registers. Ports are one read-modify-write port (bank select, address, write enable, write data) and one independent combinational drain read port (bank, address).
- Top level holds the multiplier stage, counters, bank select, and drain FSM.

## Test plan
All scenarios use D_WIDTH=8, A_PART=2, B_NUM=2, K_NUM=2.
- Single tile: A=1,2; B=3,4 for k=0, then A=5,6; B=7,8 for k=1 (8 pairs) → drain {0:1·3+5·7=38, 1:2·3+6·7=48, 2:1·4+5·8=44, 3:2·4+6·8=56}; `tile_done_out` pulses once.
- Signed wrap: A=−128, B=−128 for all 8 pairs → each C = 32768; with ACC_WIDTH forced to 16, each C = −32768 (wrap).
- Backpressure: hold `ready_C_in`=0 for 5 cycles during drain → `data_C_out`/`index_C_out` stable; order intact after release.
- Overlap: second tile streamed back-to-back while `ready_C_in`=0 → `overflow_err_out`=1 and stays set; first tile still drains correctly. Case where the last accept coincides with completion → no error, second tile drains.
- Gapped valid: random `valid_AB_in` gaps → same results as the contiguous case.
- Reset mid-tile after 5 pairs → all outputs 0; a fresh 8-pair tile produces correct sums with no residue.
